// File: rtl/mmio_tx_buffer.sv
// mmio_tx_buffer: captures stores to one MMIO word address, queues the low byte, and
// sends queued bytes as 8N1 UART frames (LSB first, line idle high).
// Latency: start bit begins one cycle after the capturing edge; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none toward the datapath; a store that arrives while full is dropped and counted.
// Optional: define MMIO_TX_PARITY_EN to add an even-parity bit between data and stop (11*CLKS_PER_BIT).
// Ports: clock, clear (async, active-high); memwrite/dataadr/writedata from the datapath store port;
//        tx/busy serial side; fifo_count/full/overflow_count status.
module mmio_tx_buffer #(
    parameter logic [31:0] MMIO_ADDR    = 32'hFFFF_0000,
    parameter int          DEPTH        = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   memwrite,
    input  logic [31:0]            dataadr,
    input  logic [31:0]            writedata,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic [7:0]             overflow_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          tx_n, pop, push_req, push, cyc_last;
`ifdef MMIO_TX_PARITY_EN
    logic          par_q, par_n;
`endif

    // Only the low byte of the store is queued.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];

    assign push_req = memwrite && (dataadr == MMIO_ADDR);
    // full is the pre-edge occupancy, so a push while full is dropped even if a pop frees a slot.
    assign full     = (fifo_count == (AW+1)'(DEPTH));
    assign push     = push_req && !full;
    assign busy     = (state != IDLE);
    assign cyc_last = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        pop     = 1'b0;
`ifdef MMIO_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                // Pop uses the registered count, so a byte captured on this edge waits one cycle.
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
`ifdef MMIO_TX_PARITY_EN
                    par_n   = ^mem[rd_ptr];
`endif
                    cyc_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    shift_n = {1'b0, shift_q[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef MMIO_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
`ifdef MMIO_TX_PARITY_EN
            PARITY: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    state_n = STOP;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cyc_last) begin
                    cyc_n   = '0;
                    state_n = IDLE;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end
            default: begin
                cyc_n   = '0;
                state_n = IDLE;
            end
        endcase

        // tx is computed from the next state so the line flop lines up with the state flop.
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef MMIO_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state          <= IDLE;
            cyc_cnt        <= '0;
            bit_cnt        <= '0;
            shift_q        <= '0;
            tx             <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            overflow_count <= '0;
`ifdef MMIO_TX_PARITY_EN
            par_q          <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_n;
            bit_cnt <= bit_n;
            shift_q <= shift_n;
            tx      <= tx_n;
`ifdef MMIO_TX_PARITY_EN
            par_q   <= par_n;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && full && (overflow_count != 8'hFF))
                overflow_count <= overflow_count + 8'd1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= writedata[7:0];
    end

endmodule

// File: tb/tb_mmio_tx_buffer.sv
// tb_mmio_tx_buffer: randomized store traffic against a queue/timing model of the MMIO UART buffer.
// Latency: expected start bit of each byte derived from store edges and frame length arithmetic.
// Backpressure: model drops stores when its occupancy reaches DEPTH and saturates the drop count.
module tb_mmio_tx_buffer;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
`ifdef MMIO_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clock = 1'b0;
    logic        clear, memwrite;
    logic [31:0] dataadr, writedata;
    logic        tx, busy, full;
    logic [3:0]  fifo_count;
    logic [7:0]  overflow_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mmio_tx_buffer #(.MMIO_ADDR(MMIO), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .clear(clear), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .full(full), .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- line receiver: decodes frames from tx, sampled at falling edges
    logic [7:0] rx_byte [$];
    int         rx_start [$];
    bit         rx_ok [$];
    bit         rx_par [$];
    bit         mon_in = 0, mon_ok = 0, mon_par = 0;
    int         mon_idx = 0, mon_st = 0, mon_b = 0;
    logic [7:0] mon_d = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (clear) begin
                mon_in = 0;
            end else begin
                if (!mon_in && tx === 1'b0) begin
                    mon_in = 1; mon_idx = 0; mon_st = cyc; mon_ok = 1; mon_d = 8'h00; mon_par = 0;
                end
                if (mon_in) begin
                    mon_b = mon_idx / CPB;
                    if (mon_b == 0) mon_ok = mon_ok & (tx === 1'b0);
                    else if (mon_b <= 8) begin
                        if (mon_idx % CPB == 0) mon_d[mon_b-1] = tx;
                        else mon_ok = mon_ok & (tx === mon_d[mon_b-1]);
                    end else if (mon_b == NBITS - 1) mon_ok = mon_ok & (tx === 1'b1);
                    else begin
                        if (mon_idx % CPB == 0) mon_par = tx;
                        else mon_ok = mon_ok & (tx === mon_par);
                    end
                    if (mon_idx == FRAME - 1) begin
                        rx_byte.push_back(mon_d); rx_start.push_back(mon_st);
                        rx_ok.push_back(mon_ok); rx_par.push_back(mon_par);
                        mon_in = 0;
                    end
                    mon_idx++;
                end
            end
        end
    end

    // ---------------- reference model: accepted bytes with the edge each one is popped on
    int         m_push [$];
    int         m_pop [$];
    logic [7:0] exp_byte [$];
    int         exp_start [$];
    int         last_pop;
    int         m_ovf;

    function automatic int occ_before(int e);
        int n = 0;
        foreach (m_push[i]) if (m_push[i] < e && m_pop[i] >= e) n++;
        return n;
    endfunction

    function automatic int occ_after(int e);
        int n = 0;
        foreach (m_push[i]) if (m_push[i] <= e && m_pop[i] > e) n++;
        return n;
    endfunction

    function automatic void model_reset();
        m_push.delete(); m_pop.delete(); exp_byte.delete(); exp_start.delete();
        last_pop = -1000000; m_ovf = 0;
    endfunction

    function automatic void flush();
        exp_byte.delete(); exp_start.delete();
        rx_byte.delete(); rx_start.delete(); rx_ok.delete(); rx_par.delete();
    endfunction

    // Called at a falling edge; the inputs are captured on the next rising edge.
    task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
        int e = cyc + 1;
        int p;
        memwrite = we; dataadr = a; writedata = d;
        if (we && a == MMIO) begin
            if (occ_before(e) < DEPTH) begin
                // Earliest pop: the edge after capture, and one idle cycle after the previous frame.
                p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
                m_push.push_back(e); m_pop.push_back(p);
                exp_byte.push_back(d[7:0]); exp_start.push_back(p);
                last_pop = p;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, MMIO, $urandom());
    endtask

    task automatic drain();
        int tgt = (last_pop + FRAME + 2 > cyc + 2) ? last_pop + FRAME + 2 : cyc + 2;
        while (cyc < tgt) idle(1);
    endtask

    // ---------------- tests
    task automatic test_reset();
        clear = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        repeat (2) @(negedge clock);
        for (int ph = 0; ph < 2; ph++) begin
            vectors += 5;
            if (tx !== 1'b1) begin miscompares++; $display("FAIL reset%0d_tx: got %b want 1", ph, tx); end
            if (busy !== 1'b0) begin miscompares++; $display("FAIL reset%0d_busy: got %b want 0", ph, busy); end
            if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset%0d_count: got %0d want 0", ph, fifo_count); end
            if (full !== 1'b0) begin miscompares++; $display("FAIL reset%0d_full: got %b want 0", ph, full); end
            if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL reset%0d_ovf: got %0d want 0", ph, overflow_count); end
            clear = 1'b0;
            model_reset(); flush();
            @(negedge clock);
        end
    endtask

    task automatic test_single();
        int p, n;
        drive(1'b1, MMIO, 32'h0000_0041);
        p = cyc;
        vectors += 3;
        if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL single_queued: count %0d want 1", fifo_count); end
        if (tx !== 1'b1) begin miscompares++; $display("FAIL single_no_bypass_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass_busy: got %b want 0", busy); end
        idle(1);
        vectors += 3;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL single_start_tx: got %b want 0", tx); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_start_busy: got %b want 1", busy); end
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL single_popped: count %0d want 0", fifo_count); end
        n = 1;
        while (busy === 1'b1 && n < 3 * FRAME) begin idle(1); if (busy === 1'b1) n++; end
        vectors++;
        if (n != FRAME) begin miscompares++; $display("FAIL single_busy_len: got %0d cycles want %0d", n, FRAME); end
        drain();
        vectors++;
        if (rx_byte.size() != 1 || rx_start.size() != 1) begin
            miscompares++; $display("FAIL single_frames: got %0d frames want 1", rx_byte.size());
        end else begin
            vectors++;
            if (rx_byte[0] !== 8'h41 || rx_start[0] != p + 1 || rx_ok[0] !== 1'b1)
                begin miscompares++; $display("FAIL single_frame: got %h@%0d ok %0b want 41@%0d ok 1", rx_byte[0], rx_start[0], rx_ok[0], p + 1); end
        end
        flush();
    endtask

    task automatic test_other_addr();
        logic [31:0] a;
        for (int i = 0; i < 11; i++) begin
            a = (i == 0) ? 32'hFFFF_0004 : (i == 1) ? 32'h1001_0008 : MMIO ^ (32'h1 << $urandom_range(31, 0));
            if (i == 10) drive(1'b0, MMIO, 32'h55);
            else drive(1'b1, a, 32'h0000_0055);
            vectors += 2;
            if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL addr%0d_count: got %0d want 0 (addr %h)", i, fifo_count, a); end
            if (tx !== 1'b1) begin miscompares++; $display("FAIL addr%0d_tx: got %b want 1", i, tx); end
        end
        idle(FRAME);
        vectors += 2;
        if (rx_byte.size() != 0) begin miscompares++; $display("FAIL addr_frames: got %0d frames want 0", rx_byte.size()); end
        if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL addr_ovf: got %0d want 0", overflow_count); end
        flush();
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 10; i++) begin
            d = $urandom(); d[7:0] = 8'h30 + 8'(i);
            drive(1'b1, MMIO, d);
        end
        vectors += 3;
        if (fifo_count !== 4'(occ_after(cyc))) begin miscompares++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, occ_after(cyc)); end
        if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
        if (overflow_count !== 8'd1) begin miscompares++; $display("FAIL ovf_drops: got %0d want 1", overflow_count); end
        drain();
        vectors++;
        if (rx_byte.size() != exp_byte.size()) begin miscompares++; $display("FAIL ovf_frames: got %0d want %0d", rx_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < rx_byte.size(); i++) begin
            vectors++;
            if (rx_byte[i] !== exp_byte[i] || rx_start[i] != exp_start[i] || rx_ok[i] !== 1'b1 || rx_byte[i] === 8'h39)
                begin miscompares++; $display("FAIL ovf_frame%0d: got %h@%0d ok %0b want %h@%0d ok 1", i, rx_byte[i], rx_start[i], rx_ok[i], exp_byte[i], exp_start[i]); end
        end
        flush();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, MMIO, 32'h0000_0000);
        drive(1'b1, MMIO, $urandom());
        drive(1'b1, MMIO, $urandom());
        memwrite = 1'b0;
        idle(CPB + 1);
        vectors += 2;
        if (tx !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: tx %b busy %b want 0 1", tx, busy); end
        if (overflow_count !== 8'd1) begin miscompares++; $display("FAIL midrst_pre_ovf: got %0d want 1", overflow_count); end
        #2 clear = 1'b1;
        #1;
        vectors += 4;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL midrst_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
        if (overflow_count !== 8'd0) begin miscompares++; $display("FAIL midrst_ovf: got %0d want 0", overflow_count); end
        repeat (2) @(negedge clock);
        clear = 1'b0;
        model_reset(); flush();
        for (int i = 0; i < 3 * FRAME; i++) begin
            idle(1);
            vectors++;
            if (tx !== 1'b1 || fifo_count !== 4'd0) begin miscompares++; $display("FAIL midrst_quiet%0d: tx %b count %0d want 1 0", i, tx, fifo_count); end
        end
        vectors++;
        if (rx_byte.size() != 0) begin miscompares++; $display("FAIL midrst_frames: got %0d want 0", rx_byte.size()); end
        flush();
    endtask

    task automatic test_back_to_back();
        int p;
        drive(1'b1, MMIO, 32'h0000_005A);
        p = cyc;
        drive(1'b1, MMIO, 32'h0000_00A5);
        drain();
        vectors++;
        if (rx_byte.size() != 2) begin
            miscompares++; $display("FAIL b2b_frames: got %0d want 2", rx_byte.size());
        end else begin
            vectors += 3;
            if (rx_byte[0] !== 8'h5A || rx_byte[1] !== 8'hA5) begin miscompares++; $display("FAIL b2b_order: got %h %h want 5a a5", rx_byte[0], rx_byte[1]); end
            if (rx_start[0] != p + 1 || rx_start[1] != p + 1 + FRAME + 1) begin miscompares++; $display("FAIL b2b_timing: got %0d %0d want %0d %0d", rx_start[0], rx_start[1], p + 1, p + FRAME + 2); end
            if (rx_ok[0] !== 1'b1 || rx_ok[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_shape: got %0b %0b want 1 1", rx_ok[0], rx_ok[1]); end
        end
        flush();
    endtask

`ifdef MMIO_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        bit         want [2];
        int         n;
        vals[0] = 8'h07; want[0] = 1'b1;
        vals[1] = 8'h03; want[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, MMIO, {24'h0, vals[k]});
            idle(1);
            n = 1;
            while (busy === 1'b1 && n < 3 * FRAME) begin idle(1); if (busy === 1'b1) n++; end
            vectors++;
            if (n != 11 * CPB) begin miscompares++; $display("FAIL par%0d_len: got %0d want %0d", k, n, 11 * CPB); end
            drain();
            vectors++;
            if (rx_byte.size() != 1) begin
                miscompares++; $display("FAIL par%0d_frames: got %0d want 1", k, rx_byte.size());
            end else begin
                vectors++;
                if (rx_byte[0] !== vals[k] || rx_par[0] !== want[k] || rx_ok[0] !== 1'b1)
                    begin miscompares++; $display("FAIL par%0d_bit: got %h par %0b ok %0b want %h par %0b", k, rx_byte[0], rx_par[0], rx_ok[0], vals[k], want[k]); end
            end
            flush();
        end
    endtask
`endif

    task automatic test_random();
        int pct [5];
        bit we;
        logic [31:0] a;
        pct[0] = 50; pct[1] = 5; pct[2] = 15; pct[3] = 2; pct[4] = 100;
        for (int seg = 0; seg < 5; seg++) begin
            for (int i = 0; i < ((seg == 4) ? 320 : 100); i++) begin
                we = ($urandom_range(99, 0) < pct[seg]);
                a = (seg == 4 || $urandom_range(3, 0) != 0) ? MMIO : $urandom();
                drive(we, a, $urandom());
                vectors += 3;
                if (fifo_count !== 4'(occ_after(cyc))) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, fifo_count, occ_after(cyc)); end
                if (full !== (occ_after(cyc) == DEPTH)) begin miscompares++; $display("FAIL rnd_full@%0d: got %b want %0b", cyc, full, occ_after(cyc) == DEPTH); end
                if (overflow_count !== 8'(m_ovf)) begin miscompares++; $display("FAIL rnd_ovf@%0d: got %0d want %0d", cyc, overflow_count, m_ovf); end
            end
        end
        vectors++;
        if (overflow_count !== 8'd255) begin miscompares++; $display("FAIL rnd_ovf_sat: got %0d want 255", overflow_count); end
        drain();
        vectors++;
        if (rx_byte.size() != exp_byte.size()) begin miscompares++; $display("FAIL rnd_frames: got %0d want %0d", rx_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < rx_byte.size(); i++) begin
            vectors++;
            if (rx_byte[i] !== exp_byte[i] || rx_start[i] != exp_start[i] || rx_ok[i] !== 1'b1)
                begin miscompares++; $display("FAIL rnd_frame%0d: got %h@%0d ok %0b want %h@%0d ok 1", i, rx_byte[i], rx_start[i], rx_ok[i], exp_byte[i], exp_start[i]); end
`ifdef MMIO_TX_PARITY_EN
            vectors++;
            if (rx_par[i] !== ^exp_byte[i]) begin miscompares++; $display("FAIL rnd_par%0d: got %0b want %0b", i, rx_par[i], ^exp_byte[i]); end
`endif
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_single();
        test_other_addr();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
`ifdef MMIO_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at cycle %0d, want finish before 200000", cyc);
        $fatal(1, "time limit");
    end

endmodule
